// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C bus master (START, addr+RW, ACK, one data byte, ACK, STOP)
// SCL/SDA_OUT are decoded from registered state so an asynchronous reset releases the bus at once.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENB,
  input  logic       START,
  input  logic [6:0] ADDR,
  input  logic       RW,
  input  logic [7:0] D,
  output logic [7:0] Q,
  output logic       Q_ready,
  output logic       BUSY,
  output logic       ACK_ERR,
  output logic       SCL,
  output logic       SDA_OUT,
  input  logic       SDA_IN
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_RDATA, S_DACK, S_STOP
  } state_t;

  state_t state, state_next;
  logic [DW-1:0] div;
  logic [1:0]    qtr;
  logic [2:0]    bit_cnt;
  logic [7:0]    addr_rw;
  logic [7:0]    data;
  logic [7:0]    rx;
  logic          sda_smp;
  logic          tick, sample, end_q, last_bit;

  assign tick     = ENB && (div == DIV_MAX);
  assign sample   = tick && (qtr == 2'd2);
  assign end_q    = tick && (qtr == 2'd3);
  assign last_bit = (bit_cnt == 3'd7);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      div     <= '0;
      qtr     <= 2'd0;
      bit_cnt <= 3'd0;
      addr_rw <= 8'h00;
      data    <= 8'h00;
      rx      <= 8'h00;
      sda_smp <= 1'b1;
      Q       <= 8'h00;
      Q_ready <= 1'b0;
      BUSY    <= 1'b0;
      ACK_ERR <= 1'b0;
    end else begin
      Q_ready <= 1'b0;
      if (ENB) begin
        state <= state_next;
        if (state == S_IDLE) begin
          div     <= '0;
          qtr     <= 2'd0;
          bit_cnt <= 3'd0;
          if (START) begin
            addr_rw <= {ADDR, RW};
            data    <= D;
            ACK_ERR <= 1'b0;
            BUSY    <= 1'b1;
          end
        end else begin
          div <= tick ? '0 : div + 1'b1;
          if (tick) qtr <= qtr + 2'd1;
          // bit counter wraps back to 0 after the eighth bit of each byte
          if (end_q && (state == S_ADDR || state == S_WDATA || state == S_RDATA))
            bit_cnt <= bit_cnt + 3'd1;
          if (sample) begin
            sda_smp <= SDA_IN;
            if (state == S_RDATA) rx <= {rx[6:0], SDA_IN};
          end
          if (end_q && state == S_AACK && sda_smp) ACK_ERR <= 1'b1;
          if (end_q && state == S_DACK && !addr_rw[0] && sda_smp) ACK_ERR <= 1'b1;
          if (end_q && state == S_RDATA && last_bit) begin
            Q       <= rx;
            Q_ready <= 1'b1;
          end
          if (end_q && state == S_STOP) BUSY <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    SCL        = 1'b1;
    SDA_OUT    = 1'b1;
    case (state)
      S_IDLE: begin
        if (ENB && START) state_next = S_START;
      end
      S_START: begin
        SCL     = ~qtr[1];
        SDA_OUT = (qtr == 2'd0);
        if (end_q) state_next = S_ADDR;
      end
      S_ADDR: begin
        SCL     = qtr[1];
        SDA_OUT = addr_rw[3'd7 - bit_cnt];
        if (end_q && last_bit) state_next = S_AACK;
      end
      S_AACK: begin
        SCL = qtr[1];
        if (end_q) state_next = sda_smp ? S_STOP : (addr_rw[0] ? S_RDATA : S_WDATA);
      end
      S_WDATA: begin
        SCL     = qtr[1];
        SDA_OUT = data[3'd7 - bit_cnt];
        if (end_q && last_bit) state_next = S_DACK;
      end
      S_RDATA: begin
        SCL = qtr[1];
        if (end_q && last_bit) state_next = S_DACK;
      end
      S_DACK: begin
        // after a read the master leaves SDA released, which is the NACK
        SCL = qtr[1];
        if (end_q) state_next = S_STOP;
      end
      S_STOP: begin
        SCL     = (qtr != 2'd0);
        SDA_OUT = qtr[1];
        if (end_q) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - self-checking bench for i2c_master against a quarter-level bus model
// The bench plays the slave on a wand-resolved SDA and compares SCL/SDA_OUT every cycle.
module tb_i2c_master;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, enb, start, rw, slave_sda;
  logic [6:0] addr;
  logic [7:0] d;
  logic [7:0] q;
  logic       q_ready, busy, ack_err, scl, sda_out, sda_in;

  int n_total = 0;
  int n_pass  = 0;

  logic q_scl [0:99];
  logic q_sda [0:99];
  logic q_slv [0:99];
  int   nq;
  logic [7:0] exp_q;
  int   busy_seen, qr_cnt;
  logic mon_bits [$];
  logic scl_prev = 1'b1;

  assign sda_in = sda_out & slave_sda;

  always #5 clk = ~clk;

  i2c_master #(.CLK_DIV(DIV)) dut (
    .CLK(clk), .RESET(rst), .ENB(enb), .START(start), .ADDR(addr), .RW(rw), .D(d),
    .Q(q), .Q_ready(q_ready), .BUSY(busy), .ACK_ERR(ack_err),
    .SCL(scl), .SDA_OUT(sda_out), .SDA_IN(sda_in)
  );

  // bus monitor: SDA value seen at every SCL rise
  always @(negedge clk) begin
    if (scl && !scl_prev) mon_bits.push_back(sda_in);
    scl_prev <= scl;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_q(input logic c, input logic s, input logic v);
    q_scl[nq] = c;
    q_sda[nq] = s;
    q_slv[nq] = v;
    nq++;
  endtask

  task automatic push_bit(input logic m, input logic v);
    push_q(1'b0, m, v);
    push_q(1'b0, m, v);
    push_q(1'b1, m, v);
    push_q(1'b1, m, v);
  endtask

  function automatic logic [7:0] mon_byte(input int s);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], mon_bits[s+i]};
    return b;
  endfunction

  // Called at a negedge; returns at the negedge where BUSY must have fallen.
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic aack, input logic dack, input logic [7:0] rd,
                         input int stall_at, input int stall_len, input int pulse_k,
                         input logic hold);
    logic [7:0] ab;
    logic       exp_err;
    int         qr_k, total, sk, pk, qi;
    ab   = {a, r};
    nq   = 0;
    qr_k = -1;
    push_q(1'b1, 1'b1, 1'b1); push_q(1'b1, 1'b0, 1'b1);
    push_q(1'b0, 1'b0, 1'b1); push_q(1'b0, 1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) push_bit(ab[i], 1'b1);
    push_bit(1'b1, !aack);
    if (aack) begin
      if (!r) begin
        for (int i = 7; i >= 0; i--) push_bit(wd[i], 1'b1);
        push_bit(1'b1, !dack);
      end else begin
        for (int i = 7; i >= 0; i--) push_bit(1'b1, rd[i]);
        qr_k  = nq * DIV;
        push_bit(1'b1, 1'b1);
        exp_q = rd;
      end
    end
    push_q(1'b0, 1'b0, 1'b1); push_q(1'b1, 1'b0, 1'b1);
    push_q(1'b1, 1'b1, 1'b1); push_q(1'b1, 1'b1, 1'b1);
    exp_err = !aack || (!r && !dack);
    total   = nq * DIV;
    sk      = (stall_len > 0) ? stall_at % total : -1;
    pk      = (pulse_k >= 0) ? pulse_k % total : -1;
    busy_seen = 0;
    qr_cnt    = 0;

    chk("busy_before_accept", busy, 1'b0);
    addr = a; rw = r; d = wd; start = 1'b1; enb = 1'b1;
    @(negedge clk);
    for (int k = 0; k < total; k++) begin
      qi = k / DIV;
      slave_sda = q_slv[qi];
      chk("scl", scl, q_scl[qi]);
      chk("sda_out", sda_out, q_sda[qi]);
      chk("q_ready", q_ready, k == qr_k);
      if (k == 0) chk("ack_err_clear_on_accept", ack_err, 1'b0);
      if (busy) busy_seen++;
      if (q_ready) qr_cnt++;
      addr = 7'($urandom);
      d    = 8'($urandom);
      rw   = 1'($urandom);
      if (!hold) start = (k == pk);
      if (k == sk) begin
        enb = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          chk("scl_stall", scl, q_scl[qi]);
          chk("sda_out_stall", sda_out, q_sda[qi]);
          chk("q_ready_stall", q_ready, 1'b0);
          if (busy) busy_seen++;
        end
        enb = 1'b1;
      end
      @(negedge clk);
    end
    slave_sda = 1'b1;
    chk("busy_done", busy, 1'b0);
    chk("scl_idle", scl, 1'b1);
    chk("sda_idle", sda_out, 1'b1);
    chk("ack_err_final", ack_err, exp_err);
    chk("q_final", q, exp_q);
  endtask

  initial begin
    rst = 1'b1; enb = 1'b0; start = 1'b0; addr = 7'h00; rw = 1'b0; d = 8'h00;
    slave_sda = 1'b1; exp_q = 8'h00;
    #1;
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_q_ready", q_ready, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_q", q, 8'h00);
    @(negedge clk);
    rst = 1'b0; enb = 1'b1;
    repeat (3) @(negedge clk);

    mon_bits.delete();
    run_txn(7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0, 0, -1, 1'b0);
    chk("write_busy_cycles", busy_seen, 320);
    chk("write_mon_bits", mon_bits.size(), 19);
    chk("write_addr_byte", mon_byte(0), 8'h54);
    chk("write_addr_ack", mon_bits[8], 1'b0);
    chk("write_data_byte", mon_byte(9), 8'hA5);
    chk("write_data_ack", mon_bits[17], 1'b0);
    chk("write_ack_err", ack_err, 1'b0);
    repeat (2) @(negedge clk);

    run_txn(7'h33, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, 0, 0, -1, 1'b0);
    chk("nack_busy_cycles", busy_seen, 176);
    chk("nack_ack_err", ack_err, 1'b1);
    repeat (2) @(negedge clk);

    run_txn(7'h50, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h3C, 0, 0, -1, 1'b0);
    chk("read_q", q, 8'h3C);
    chk("read_q_ready_count", qr_cnt, 1);
    repeat (2) @(negedge clk);

    run_txn(7'h50, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 50 * DIV, 50, -1, 1'b0);
    chk("stall_busy_cycles", busy_seen, 370);
    chk("stall_q", q, 8'h3C);
    repeat (2) @(negedge clk);

    run_txn(7'h11, 1'b0, 8'h96, 1'b1, 1'b0, 8'h00, 0, 0, 137, 1'b0);
    repeat (2) @(negedge clk);

    run_txn(7'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 0, 0, -1, 1'b1);
    run_txn(7'h22, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3, 0, 0, -1, 1'b0);
    repeat (2) @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      run_txn(7'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) != 0), 8'($urandom), $urandom_range(0, 1000),
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0,
              ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1000) : -1, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    addr = 7'h2A; rw = 1'b0; d = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 52 * DIV; k++) begin
      slave_sda = (k / DIV >= 36 && k / DIV < 40) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    chk("pre_reset_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_scl", scl, 1'b1);
    chk("async_rst_sda", sda_out, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_q", q, 8'h00);
    chk("async_rst_ack_err", ack_err, 1'b0);
    exp_q = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    slave_sda = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_scl", scl, 1'b1);
      chk("post_rst_sda", sda_out, 1'b1);
      chk("post_rst_busy", busy, 1'b0);
    end

    run_txn(7'h41, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, 0, 0, -1, 1'b0);
    chk("final_q_untouched_by_write", q, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

Single-byte I2C bus master driving the `SCL`/`SDA` pair consumed by `i2c_slave`. One transaction per request: START, 7-bit address plus R/W, slave ACK, then one data byte (write from `D` or read into `Q`) with its acknowledge, then STOP. It replaces the behavioural tester as the producer of bus traffic and is the upstream stage of `i2c_slave`. `SDA_OUT` drives the shared `wand` SDA net, and `SDA_IN` samples it.

## Interface
- `CLK_DIV`, default 4: `CLK` cycles per SCL quarter-period, legal range ≥2. One SCL period is 4·`CLK_DIV` cycles.
- `CLK` in 1: system clock, rising edge.
- `RESET` in 1: reset, asynchronous, active-high.
- `ENB` in 1: enable. When low, the divider, FSM and all outputs hold.
- `START` in 1: transaction request, sampled in IDLE only.
- `ADDR` in 7: slave address, latched on accept.
- `RW` in 1: 0 = write, 1 = read. Latched on accept.
- `D` in 8: write byte, latched on accept.
- `Q` out 8: last read byte.
- `Q_ready` out 1: one-cycle pulse when `Q` updates.
- `BUSY` out 1: transaction in progress.
- `ACK_ERR` out 1: NACK seen. Sticky until the next accepted `START`.
- `SCL` out 1: bus clock, 1 = released/high.
- `SDA_OUT` out 1: SDA drive onto the `wand` net, 1 = released.
- `SDA_IN` in 1: resolved SDA bus value.

## Operation
- Reset values:
  - `SCL`=1, `SDA_OUT`=1
  - `BUSY`=0, `Q_ready`=0, `ACK_ERR`=0, `Q`=8'h00
  - FSM in IDLE, divider and counters at 0
- Tick: the divider counts enabled cycles 0..`CLK_DIV`-1. The quarter index (0–3) advances on the wrap.
- States: IDLE → START → ADDR → AACK → (WDATA | RDATA) → DACK → STOP → IDLE.
- IDLE: `START`=1 with `ENB`=1 latches `ADDR`/`RW`/`D`, clears `ACK_ERR`, and sets `BUSY`=1 on that edge.
- START, 4 quarters:
  - Q0: SCL=1, SDA=1
  - Q1: SCL=1, SDA=0
  - Q2, Q3: SCL=0, SDA=0
- Data bit, 4 quarters:
  - Q0: SCL=0, SDA changes
  - Q1: SCL=0
  - Q2, Q3: SCL=1
  - `SDA_IN` is sampled on the edge ending Q2.
- ADDR: 8 bits, MSB first, shifting out {`ADDR`,`RW`}.
- AACK: master releases SDA.
  - `SDA_IN`=1 → `ACK_ERR`=1, next state STOP (data phase skipped).
- WDATA: 8 bits of the latched `D`, MSB first.
- DACK after a write: master releases SDA. `SDA_IN`=1 sets `ACK_ERR`=1, and the FSM still goes to STOP.
- RDATA: master releases SDA and shifts in 8 sampled bits, MSB first.
  - At the end of bit 8 (edge ending Q3), `Q` loads the assembled byte and `Q_ready` pulses for one cycle.
- DACK after a read: master drives NACK (`SDA_OUT`=1).
- STOP, 4 quarters:
  - Q0: SCL=0, SDA=0
  - Q1: SCL=1, SDA=0
  - Q2: SCL=1, SDA=1
  - Q3: SCL=1, SDA=1
  - The edge ending Q3 sets `BUSY`=0 and the FSM returns to IDLE.
- Not supported: clock stretching, arbitration, repeated START.

## Timing
- Full transaction: 4 + 36 + 36 + 4 = 80 quarters = 80·`CLK_DIV` enabled cycles (320 at default).
- Address-NACK transaction: 4 + 36 + 4 = 44 quarters (176 at default).
- `BUSY` is high from the accepting edge through the last STOP quarter.
- `START` while `BUSY`=1 is ignored.
- `START` held high re-arms: the next transaction is accepted on the first IDLE cycle after `BUSY` falls.
- `ENB` low at any point freezes divider, quarter, bit counter and outputs. Resuming continues exactly where it stopped, with no glitch on SCL/SDA.
- `RESET` asserted mid-transaction:
  - Immediately, without waiting for a clock: `SCL`=1, `SDA_OUT`=1, `BUSY`=0, FSM IDLE.
  - No STOP is generated.
  - `Q` and `ACK_ERR` clear.
- `Q` holds its value between reads. Writes never modify `Q`.

## Test plan
- Async reset: assert `RESET` in the middle of WDATA, between clock edges → `SCL`=1, `SDA_OUT`=1, `BUSY`=0 within the same timestep. Release → IDLE, no bus activity.
- Write with ACK (`CLK_DIV`=4): `ADDR`=7'h2A, `RW`=0, `D`=8'hA5, `SDA_IN` pulled low in both ACK bits.
  - SDA bits sampled at SCL rises: 0x54 then 0xA5.
  - `BUSY` high exactly 320 cycles, `ACK_ERR`=0.
  - `i2c_slave` with matching address produces `Q`=8'hA5.
- Address NACK: `SDA_IN` held 1 → STOP directly after AACK, `ACK_ERR`=1, `BUSY` high exactly 176 cycles.
- Read: `ADDR`=7'h50, `RW`=1, bench drives 0x3C on `SDA_IN` during RDATA.
  - `Q`=8'h3C, `Q_ready` high exactly one cycle.
  - `SDA_OUT`=1 throughout the final ACK bit.
- Enable stall: deassert `ENB` for 50 cycles during RDATA → SCL/SDA frozen, `BUSY` spans 370 cycles, `Q` still 8'h3C.
- Request collisions: `START` pulsed during `BUSY` → ignored. `START` held high → second transaction accepted on the cycle after `BUSY` falls, and `ACK_ERR` clears on that accept.
